// File: rtl/decoder_al_seq_pkg.sv
// decoder_al_seq_pkg: shared state encodings and mode constants for the scan/direct decoder.
package decoder_al_seq_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN_ON, SCAN_BLANK} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  function automatic logic is_scan(state_t s);
    return s == SCAN_ON || s == SCAN_BLANK;
  endfunction
endpackage

// File: rtl/decoder_al_seq_core.sv
// decoder_al_seq_core: combinational SEL_W-to-2**SEL_W active-low decode with enable.
module decoder_al_seq_core #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [2**SEL_W-1:0]   y_o
);
  always_comb begin
    y_o = '1;
    y_o[sel_i] = ~en_i;
  end
endmodule

// File: rtl/decoder_al_seq.sv
// decoder_al_seq: registered active-low decoder with direct mode and self-sequencing scan mode.
module decoder_al_seq
  import decoder_al_seq_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic                mode_in,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic [DWELL_W-1:0]  dwell_in,
  input  logic [SEL_W-1:0]    last_in,
  output logic [2**SEL_W-1:0] y_out,
  output logic [SEL_W-1:0]    idx_out,
  output logic                wrap_out
);
  localparam int OUT_W = 2**SEL_W;
  localparam int BW = BLANK > 1 ? $clog2(BLANK) : 1;
  state_t st_q, st_d, rs_q, rs_d, es;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic wrap_q, wrap_d, last_hit, blank_end;
  // rs_q remembers the scan phase frozen by en_in=0; IDLE there means no frozen scan
  always_comb begin
    es = st_q == IDLE ? rs_q : st_q;
    last_hit = idx_q >= last_in;
    blank_end = bcnt_q == BW'(BLANK - 1);
    st_d = es;
    rs_d = IDLE;
    idx_d = idx_q;
    cnt_d = cnt_q;
    bcnt_d = bcnt_q;
    wrap_d = 1'b0;
    if (!en_in) begin
      st_d = IDLE;
      rs_d = is_scan(es) ? es : IDLE;
    end else if (mode_in == MODE_DIRECT) begin
      st_d = DIRECT;
      idx_d = sel_in;
    end else if (!is_scan(es)) begin
      st_d = SCAN_ON;
      idx_d = '0;
      cnt_d = '0;
      bcnt_d = '0;
    end else if (es == SCAN_ON) begin
      if (cnt_q >= dwell_in) begin
        st_d = BLANK > 0 ? SCAN_BLANK : SCAN_ON;
        idx_d = last_hit ? '0 : idx_q + 1'b1;
        wrap_d = last_hit;
        cnt_d = '0;
        bcnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      st_d = blank_end ? SCAN_ON : SCAN_BLANK;
      bcnt_d = blank_end ? '0 : bcnt_q + 1'b1;
    end
  end
  decoder_al_seq_core #(.SEL_W(SEL_W)) u_core (
    .sel_i (idx_d),
    .en_i  (st_d == DIRECT || st_d == SCAN_ON),
    .y_o   (y_d)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q <= IDLE;
      rs_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      y_q <= '1;
      wrap_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rs_q <= rs_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      y_q <= y_d;
      wrap_q <= wrap_d;
    end
  end
  assign y_out = y_q;
  assign idx_out = idx_q;
  assign wrap_out = wrap_q;
endmodule

// File: tb/tb_decoder_al_seq.sv
// tb_decoder_al_seq: vector table, directed scan/freeze/edge/reset sequences and a randomized run against a model.
module tb_decoder_al_seq;
  import decoder_al_seq_pkg::*;
  localparam int BLANK = 1;
  logic clk_in = 1'b0;
  logic rst_in, en_in, mode_in, wrap_out;
  logic [3:0] sel_in, last_in, idx_out;
  logic [7:0] dwell_in;
  logic [15:0] y_out;
  int checks = 0, passed = 0;
  int m_idx, m_pos, m_bl;
  bit m_scan = 1'b0, m_blank = 1'b0;
  logic [15:0] e_y;
  logic [3:0] e_idx;
  logic e_wrap;
  typedef struct {logic en; logic mode; logic [3:0] sel; logic [15:0] y; logic [3:0] idx;} vec_t;
  vec_t tbl [7];
  logic [15:0] fy [6];
  logic [3:0] fi [6];

  always #5 clk_in = ~clk_in;

  decoder_al_seq #(.SEL_W(4), .DWELL_W(8), .BLANK(BLANK)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .mode_in(mode_in), .sel_in(sel_in),
    .dwell_in(dwell_in), .last_in(last_in), .y_out(y_out), .idx_out(idx_out), .wrap_out(wrap_out)
  );

  function automatic logic [15:0] al(logic [3:0] i);
    return ~(16'd1 << i);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  task automatic ex(string nm, logic [15:0] y, logic [3:0] i, logic w);
    chk({nm, " y"}, 32'(y_out), 32'(y));
    chk({nm, " idx"}, 32'(idx_out), 32'(i));
    chk({nm, " wrap"}, 32'(wrap_out), 32'(w));
  endtask

  // Scan viewed as steps: dwell+1 lit cycles (dwell re-read every cycle), then BLANK dark cycles.
  task automatic model();
    e_wrap = 1'b0;
    if (rst_in) begin
      m_scan = 1'b0;
      m_blank = 1'b0;
      e_idx = 4'd0;
    end else if (en_in && mode_in == MODE_DIRECT) begin
      m_scan = 1'b0;
      m_blank = 1'b0;
      e_idx = sel_in;
    end else if (en_in) begin
      if (!m_scan) begin
        m_scan = 1'b1;
        m_idx = 0;
        m_pos = 0;
        m_blank = 1'b0;
      end else if (m_blank) begin
        if (m_bl >= BLANK) begin
          m_blank = 1'b0;
          m_pos = 0;
        end else m_bl++;
      end else if (m_pos >= int'(dwell_in)) begin
        e_wrap = m_idx >= int'(last_in);
        m_idx = e_wrap ? 0 : (m_idx + 1) % 16;
        m_pos = 0;
        if (BLANK > 0) begin
          m_blank = 1'b1;
          m_bl = 1;
        end
      end else m_pos++;
      e_idx = 4'(m_idx);
    end
    e_y = (rst_in || !en_in || (mode_in == MODE_SCAN && m_blank)) ? 16'hFFFF : al(e_idx);
  endtask

  task automatic tick();
    @(posedge clk_in);
    model();
    #1;
  endtask

  task automatic restart_scan();
    mode_in = MODE_DIRECT;
    tick();
    mode_in = MODE_SCAN;
  endtask

  initial begin
    rst_in = 1'b1;
    en_in = 1'($urandom);
    mode_in = 1'($urandom);
    sel_in = 4'($urandom);
    dwell_in = 8'($urandom);
    last_in = 4'($urandom);
    for (int c = 0; c < 2; c++) begin
      tick();
      ex("reset", 16'hFFFF, 4'd0, 1'b0);
    end
    rst_in = 1'b0;
    tbl = '{'{1'b1, 1'b0, 4'd5, 16'hFFDF, 4'd5}, '{1'b1, 1'b0, 4'd0, 16'hFFFE, 4'd0},
            '{1'b1, 1'b0, 4'd15, 16'h7FFF, 4'd15}, '{1'b0, 1'b0, 4'd2, 16'hFFFF, 4'd15},
            '{1'b1, 1'b0, 4'd3, 16'hFFF7, 4'd3}, '{1'b0, 1'b1, 4'd9, 16'hFFFF, 4'd3},
            '{1'b1, 1'b0, 4'd10, 16'hFBFF, 4'd10}};
    for (int i = 0; i < 7; i++) begin
      en_in = tbl[i].en;
      mode_in = tbl[i].mode;
      sel_in = tbl[i].sel;
      tick();
      ex($sformatf("vec%0d", i), tbl[i].y, tbl[i].idx, 1'b0);
    end
    en_in = 1'b1;
    mode_in = MODE_DIRECT;
    for (int s = 0; s < 16; s++) begin
      sel_in = 4'(s);
      tick();
      ex($sformatf("sweep%0d", s), ~(16'd1 << s), 4'(s), 1'b0);
      chk("sweep onehot", 32'($countones(~y_out)), 32'd1);
    end
    dwell_in = 8'd2;
    last_in = 4'd3;
    mode_in = MODE_SCAN;
    for (int c = 0; c < 17; c++) begin
      int k;
      k = c % 16;
      tick();
      ex($sformatf("scan%0d", c), (k % 4 == 3) ? 16'hFFFF : al(4'(k / 4)),
         4'((k % 4 == 3) ? (k / 4 + 1) % 4 : k / 4), k == 15);
    end
    restart_scan();
    for (int c = 0; c < 10; c++) tick();
    ex("pre_freeze", 16'hFFFB, 4'd2, 1'b0);
    en_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      ex("frozen", 16'hFFFF, 4'd2, 1'b0);
    end
    en_in = 1'b1;
    fy = '{16'hFFFB, 16'hFFFF, 16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFFF};
    fi = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0};
    for (int c = 0; c < 6; c++) begin
      tick();
      ex($sformatf("resume%0d", c), fy[c], fi[c], c == 5);
    end
    dwell_in = 8'd0;
    last_in = 4'd0;
    restart_scan();
    for (int c = 0; c < 6; c++) begin
      tick();
      ex($sformatf("edge0_%0d", c), (c % 2 == 1) ? 16'hFFFF : 16'hFFFE, 4'd0, c % 2 == 1);
    end
    last_in = 4'd15;
    restart_scan();
    for (int c = 0; c < 7; c++) tick();
    ex("idx3", 16'hFFF7, 4'd3, 1'b0);
    last_in = 4'd1;
    tick();
    ex("last_shrink", 16'hFFFF, 4'd0, 1'b1);
    tick();
    ex("after_shrink", 16'hFFFE, 4'd0, 1'b0);
    dwell_in = 8'd2;
    last_in = 4'd3;
    restart_scan();
    for (int c = 0; c < 9; c++) tick();
    ex("pre_rst", 16'hFFFB, 4'd2, 1'b0);
    rst_in = 1'b1;
    tick();
    ex("mid_rst", 16'hFFFF, 4'd0, 1'b0);
    rst_in = 1'b0;
    tick();
    ex("post_rst", 16'hFFFE, 4'd0, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    ex("post_rst_blank", 16'hFFFF, 4'd1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      rst_in = $urandom_range(0, 199) == 0;
      en_in = $urandom_range(0, 9) != 0;
      mode_in = $urandom_range(0, 19) != 0;
      sel_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dwell_in = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) last_in = 4'($urandom);
      tick();
      ex("rand", e_y, e_idx, e_wrap);
      chk("rand onehot", 32'($countones(~y_out) <= 1), 32'd1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
